intra_fir4_pipe: RTL

//  Parametrised, pipelined 4-tap intra angular interpolation filter for the VVC intra predictor.

---
 rtl/intra_fir_pkg.sv | 60 ++++++
 rtl/intra_fir4_tap.sv | 34 +++
 rtl/intra_fir4_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/intra_fir_pkg.sv
// Shared coefficient tables and helpers for the VVC intra 4-tap interpolation filters.
// Rows are {c0,c1,c2,c3}; every row sums to 64.
package intra_fir_pkg;

    localparam int TAB_COEF_W = 8;
    localparam int TAB_SHIFT  = 6;
    localparam int TAB_ROUND  = 32;

    typedef enum logic {
        MODE_CUBIC = 1'b0,
        MODE_GAUSS = 1'b1
    } filt_mode_e;

    typedef logic signed [TAB_COEF_W-1:0] coef_t;
    typedef coef_t [0:3] coef_set_t;

    function automatic coef_set_t cs(input int c0, input int c1, input int c2, input int c3);
        coef_set_t r;
        r[0] = coef_t'(c0);
        r[1] = coef_t'(c1);
        r[2] = coef_t'(c2);
        r[3] = coef_t'(c3);
        return r;
    endfunction

    localparam coef_set_t FC_TAB [32] = '{
        cs( 0, 64,  0,  0), cs(-1, 63,  2,  0), cs(-2, 62,  4,  0), cs(-2, 60,  7, -1),
        cs(-2, 58, 10, -2), cs(-3, 57, 12, -2), cs(-4, 56, 14, -2), cs(-4, 55, 15, -2),
        cs(-4, 54, 16, -2), cs(-5, 53, 18, -2), cs(-6, 52, 20, -2), cs(-6, 49, 24, -3),
        cs(-6, 46, 28, -4), cs(-5, 44, 29, -4), cs(-4, 42, 30, -4), cs(-4, 39, 33, -4),
        cs(-4, 36, 36, -4), cs(-4, 33, 39, -4), cs(-4, 30, 42, -4), cs(-5, 29, 44, -4),
        cs(-6, 28, 46, -4), cs(-6, 24, 49, -3), cs(-6, 20, 52, -2), cs(-5, 18, 53, -2),
        cs(-4, 16, 54, -2), cs(-4, 15, 55, -2), cs(-4, 14, 56, -2), cs(-3, 12, 57, -2),
        cs(-2, 10, 58, -2), cs(-2,  7, 60, -1), cs(-2,  4, 62,  0), cs(-1,  2, 63,  0)
    };

    localparam coef_set_t FG_TAB [32] = '{
        cs(16, 32, 16,  0), cs(16, 32, 16,  0), cs(15, 31, 17,  1), cs(15, 31, 17,  1),
        cs(14, 30, 18,  2), cs(14, 30, 18,  2), cs(13, 29, 19,  3), cs(13, 29, 19,  3),
        cs(12, 28, 20,  4), cs(12, 28, 20,  4), cs(11, 27, 21,  5), cs(11, 27, 21,  5),
        cs(10, 26, 22,  6), cs(10, 26, 22,  6), cs( 9, 25, 23,  7), cs( 9, 25, 23,  7),
        cs( 8, 24, 24,  8), cs( 8, 24, 24,  8), cs( 7, 23, 25,  9), cs( 7, 23, 25,  9),
        cs( 6, 22, 26, 10), cs( 6, 22, 26, 10), cs( 5, 21, 27, 11), cs( 5, 21, 27, 11),
        cs( 4, 20, 28, 12), cs( 4, 20, 28, 12), cs( 3, 19, 29, 13), cs( 3, 19, 29, 13),
        cs( 2, 18, 30, 14), cs( 2, 18, 30, 14), cs( 1, 17, 31, 15), cs( 1, 17, 31, 15)
    };

    // Saturate a rounded filter result to [0, 2^bd-1]; bd is at most 12.
    function automatic logic [15:0] clip_sample(input logic signed [31:0] v, input int unsigned bd);
        logic signed [31:0] maxv;
        maxv = (32'sd1 <<< bd) - 32'sd1;
        if (v < 0)
            return '0;
        else if (v > maxv)
            return maxv[15:0];
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/intra_fir4_tap.sv
// Combinational 4-tap shift-add products for one predicted sample.
// Unsigned reference samples times signed coefficients; outputs the four signed products.
module intra_fir4_tap #(
    parameter int BIT_DEPTH = 8,
    parameter int COEF_W    = 8,
    parameter int ACC_W     = BIT_DEPTH + COEF_W + 2
) (
    input  logic [4*BIT_DEPTH-1:0] ref_i,
    input  logic [4*COEF_W-1:0]    coef_i,
    output logic [4*ACC_W-1:0]     prod_o
);

    logic signed [ACC_W-1:0] smp;
    logic signed [ACC_W-1:0] acc;

    // Two's-complement coefficient: lower bits add shifted samples, the sign bit subtracts.
    always_comb begin
        prod_o = '0;
        smp    = '0;
        acc    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            smp = ACC_W'(ref_i[k*BIT_DEPTH +: BIT_DEPTH]);
            acc = '0;
            for (int unsigned b = 0; b < COEF_W - 1; b++) begin
                if (coef_i[k*COEF_W + b])
                    acc = acc + (smp <<< b);
            end
            if (coef_i[k*COEF_W + COEF_W - 1])
                acc = acc - (smp <<< (COEF_W - 1));
            prod_o[k*ACC_W +: ACC_W] = acc;
        end
    end

endmodule

// File: rtl/intra_fir4_pipe.sv
// Pipelined 4-tap intra angular interpolation filter: lookup (S1), products (S2), round/clip (S3).
// Valid/ready elastic pipeline with bubble collapsing; only valid bits and outputs are reset.
module intra_fir4_pipe
    import intra_fir_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int BIT_DEPTH = 8,
    parameter int COEF_W    = 8,
    parameter int ACC_W     = BIT_DEPTH + COEF_W + 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [(N_SAMPLES+3)*BIT_DEPTH-1:0] in_ref,
    input  logic [4:0]                       in_fract,
    input  logic                             in_mode,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_SAMPLES*BIT_DEPTH-1:0]   out_pred,
    output logic                             out_last
);

    localparam int REF_W  = (N_SAMPLES + 3) * BIT_DEPTH;
    localparam int PRED_W = N_SAMPLES * BIT_DEPTH;
    localparam int PROD_W = 4 * ACC_W;

    logic v1_q, v2_q, v3_q;
    logic en1, en2, en3;

    logic [REF_W-1:0]           ref1_q;
    logic [4*COEF_W-1:0]        coef1_q;
    logic                       last1_q;
    logic [N_SAMPLES*PROD_W-1:0] prod_d;
    logic [N_SAMPLES*PROD_W-1:0] prod2_q;
    logic                       last2_q;
    logic [PRED_W-1:0]          pred_d;
    logic [PRED_W-1:0]          pred_q;
    logic                       last3_q;

    filt_mode_e                 mode_sel;
    coef_set_t                  cs_sel;
    logic [4*COEF_W-1:0]        coef_d;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    rnd;

    assign en3       = !v3_q || out_ready;
    assign en2       = !v2_q || en3;
    assign en1       = !v1_q || en2;
    assign in_ready  = en1;
    assign out_valid = v3_q;
    assign out_pred  = pred_q;
    assign out_last  = last3_q;

    always_comb begin
        mode_sel = filt_mode_e'(in_mode);
        cs_sel   = (mode_sel == MODE_GAUSS) ? FG_TAB[in_fract] : FC_TAB[in_fract];
        coef_d   = '0;
        for (int unsigned k = 0; k < 4; k++)
            coef_d[k*COEF_W +: COEF_W] = COEF_W'($signed(cs_sel[k]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (en1) v1_q <= in_valid;
            if (en2) v2_q <= v1_q;
            if (en3) v3_q <= v2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en1) begin
            ref1_q  <= in_ref;
            coef1_q <= coef_d;
            last1_q <= in_last;
        end
        if (en2) begin
            prod2_q <= prod_d;
            last2_q <= last1_q;
        end
    end

    // Tap i reads window samples i..i+3, which are contiguous in ref1_q.
    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_tap
        intra_fir4_tap #(
            .BIT_DEPTH(BIT_DEPTH),
            .COEF_W   (COEF_W),
            .ACC_W    (ACC_W)
        ) u_tap (
            .ref_i (ref1_q[i*BIT_DEPTH +: 4*BIT_DEPTH]),
            .coef_i(coef1_q),
            .prod_o(prod_d[i*PROD_W +: PROD_W])
        );
    end

    always_comb begin
        pred_d = '0;
        sum    = '0;
        rnd    = '0;
        for (int unsigned i = 0; i < N_SAMPLES; i++) begin
            sum = '0;
            for (int unsigned k = 0; k < 4; k++)
                sum = sum + $signed(prod2_q[(i*4 + k)*ACC_W +: ACC_W]);
            rnd = (sum + ACC_W'(TAB_ROUND)) >>> TAB_SHIFT;
            pred_d[i*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(clip_sample(32'(rnd), BIT_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q  <= '0;
            last3_q <= 1'b0;
        end else if (en3) begin
            pred_q  <= pred_d;
            last3_q <= last2_q;
        end
    end

endmodule
